if_id_pipe: RTL and testbench



---
 rtl/if_id_pipe.sv | 105 ++++++++++
 tb/tb_if_id_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with a one-entry skid buffer and branch flush.
// Define IF_ID_PERF_EN to add saturating stall_cnt/flush_cnt outputs.
module if_id_pipe #(
   parameter logic [31:0] NOP = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_ir,
   input  logic [31:0] if_npc,
   input  logic        if_valid,
   output logic        if_ready,
   input  logic        flush,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_ir,
   output logic [31:0] id_npc
`ifdef IF_ID_PERF_EN
   ,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
`endif
);

   // Encoding is {id_valid, sk_valid}; (0,1) has no name and cannot be entered.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      FULL  = 2'b11
   } state_e;

   state_e      state, state_nxt;
   logic        sk_valid;
   logic [31:0] sk_ir, sk_npc;
   logic [31:0] ir_nxt, npc_nxt, sk_ir_nxt, sk_npc_nxt;
   logic        accept, drain, out_load;

   assign id_valid = state[1];
   assign sk_valid = state[0];
   // if_ready depends only on the skid flop, never on id_ready.
   assign if_ready = ~sk_valid;

   assign accept   = if_valid & if_ready & ~flush;
   assign drain    = id_valid & id_ready;
   assign out_load = ~id_valid | drain;

   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      state_nxt  = state;
      ir_nxt     = id_ir;
      npc_nxt    = id_npc;
      sk_ir_nxt  = sk_ir;
      sk_npc_nxt = sk_npc;
      if (flush) begin
         state_nxt = EMPTY;
         ir_nxt    = NOP;
      end else if (out_load) begin
         if (sk_valid) begin
            state_nxt = ONE;
            ir_nxt    = sk_ir;
            npc_nxt   = sk_npc;
         end else if (accept) begin
            state_nxt = ONE;
            ir_nxt    = if_ir;
            npc_nxt   = if_npc;
         end else begin
            state_nxt = EMPTY;
            ir_nxt    = NOP;
         end
      end else if (accept) begin
         state_nxt  = FULL;
         sk_ir_nxt  = if_ir;
         sk_npc_nxt = if_npc;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         id_ir  <= NOP;
         id_npc <= '0;
         sk_ir  <= '0;
         sk_npc <= '0;
      end else begin
         state  <= state_nxt;
         id_ir  <= ir_nxt;
         id_npc <= npc_nxt;
         sk_ir  <= sk_ir_nxt;
         sk_npc <= sk_npc_nxt;
      end
   end

`ifdef IF_ID_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (id_valid && !id_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
         if (flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed self-checking bench for if_id_pipe: stream, stall/skid, flush, async reset.
module tb_if_id_pipe;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic [31:0] if_ir;
   logic [31:0] if_npc;
   logic        if_valid;
   logic        if_ready;
   logic        flush;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_ir;
   logic [31:0] id_npc;
`ifdef IF_ID_PERF_EN
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   if_id_pipe #(.NOP(NOP)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_ir    (if_ir),
      .if_npc   (if_npc),
      .if_valid (if_valid),
      .if_ready (if_ready),
      .flush    (flush),
      .id_valid (id_valid),
      .id_ready (id_ready),
      .id_ir    (id_ir),
      .id_npc   (id_npc)
`ifdef IF_ID_PERF_EN
      ,
      .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] npc,
                        input logic rdy, input logic fl);
      if_valid = v;
      if_ir    = ir;
      if_npc   = npc;
      id_ready = rdy;
      flush    = fl;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #2;
      check("rst_id_valid", {31'b0, id_valid}, 32'd0);
      check("rst_id_ir", id_ir, NOP);
      check("rst_id_npc", id_npc, 32'h0);
      check("rst_if_ready", {31'b0, if_ready}, 32'd1);
      #6;
      rst_n = 1'b1;

      // Streaming: one word per cycle, one cycle latency.
      drive(1'b1, 32'h2002_0005, 32'h4, 1'b1, 1'b0);
      tick();
      check("a_valid", {31'b0, id_valid}, 32'd1);
      check("a_ir", id_ir, 32'h2002_0005);
      check("a_npc", id_npc, 32'h4);
      drive(1'b1, 32'h0041_1820, 32'h8, 1'b1, 1'b0);
      tick();
      check("b_ir", id_ir, 32'h0041_1820);
      check("b_npc", id_npc, 32'h8);
      check("b_if_ready", {31'b0, if_ready}, 32'd1);

      // Stall three cycles in ONE: C goes to skid, D waits at the input.
      drive(1'b1, 32'h8C22_0010, 32'hC, 1'b0, 1'b0);
      tick();
      check("stall1_if_ready", {31'b0, if_ready}, 32'd0);
      check("stall1_ir", id_ir, 32'h0041_1820);
      drive(1'b1, 32'hAC43_0014, 32'h10, 1'b0, 1'b0);
      tick();
      check("stall2_ir", id_ir, 32'h0041_1820);
      check("stall2_if_ready", {31'b0, if_ready}, 32'd0);
      tick();
      check("stall3_ir", id_ir, 32'h0041_1820);
      check("stall3_npc", id_npc, 32'h8);
      check("stall3_valid", {31'b0, id_valid}, 32'd1);

      // Release: skid word first, ready returns on the same edge.
      id_ready = 1'b1;
      tick();
      check("rel_ir", id_ir, 32'h8C22_0010);
      check("rel_npc", id_npc, 32'hC);
      check("rel_if_ready", {31'b0, if_ready}, 32'd1);
      tick();
      check("d_ir", id_ir, 32'hAC43_0014);
      check("d_npc", id_npc, 32'h10);

      // Refill to FULL, then flush with a word presented.
      drive(1'b1, 32'h1000_FFFF, 32'h14, 1'b0, 1'b0);
      tick();
      check("full_if_ready", {31'b0, if_ready}, 32'd0);
      check("full_ir", id_ir, 32'hAC43_0014);
      drive(1'b1, 32'hDEAD_BEEF, 32'h18, 1'b0, 1'b1);
      tick();
      check("fl_valid", {31'b0, id_valid}, 32'd0);
      check("fl_ir", id_ir, NOP);
      check("fl_if_ready", {31'b0, if_ready}, 32'd1);
      check("fl_npc_hold", id_npc, 32'h10);

      // Flush with drain while ready: the presented word H is dropped.
      drive(1'b1, 32'h0062_2020, 32'h1C, 1'b1, 1'b0);
      tick();
      check("g_ir", id_ir, 32'h0062_2020);
      check("g_npc", id_npc, 32'h1C);
      drive(1'b1, 32'hCAFE_0001, 32'h20, 1'b1, 1'b1);
      tick();
      check("fl2_valid", {31'b0, id_valid}, 32'd0);
      check("fl2_ir", id_ir, NOP);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      check("fl2_drop_valid", {31'b0, id_valid}, 32'd0);
      check("fl2_drop_npc", id_npc, 32'h1C);
`ifdef IF_ID_PERF_EN
      check("perf_stall", {16'b0, stall_cnt}, 32'd5);
      check("perf_flush", {16'b0, flush_cnt}, 32'd2);
`endif

      // Reach FULL again, then assert reset between clock edges.
      drive(1'b1, 32'h0123_4567, 32'h24, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h89AB_CDEF, 32'h28, 1'b0, 1'b0);
      tick();
      check("pre_rst_if_ready", {31'b0, if_ready}, 32'd0);
      check("pre_rst_ir", id_ir, 32'h0123_4567);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", {31'b0, id_valid}, 32'd0);
      check("arst_ir", id_ir, NOP);
      check("arst_npc", id_npc, 32'h0);
      check("arst_if_ready", {31'b0, if_ready}, 32'd1);
`ifdef IF_ID_PERF_EN
      check("arst_stall", {16'b0, stall_cnt}, 32'd0);
      check("arst_flush", {16'b0, flush_cnt}, 32'd0);
`endif
      #2;
      rst_n = 1'b1;

      // After reset the skid word must not reappear; fresh data flows.
      drive(1'b1, 32'h5555_AAAA, 32'h2C, 1'b1, 1'b0);
      tick();
      check("post_rst_ir", id_ir, 32'h5555_AAAA);
      check("post_rst_npc", id_npc, 32'h2C);

`ifdef IF_ID_PERF_EN
      // Saturation: preset both counters two below the top.
      drive(1'b1, 32'h7777_0000, 32'h30, 1'b0, 1'b0);
      force dut.stall_cnt = 16'hFFFD;
      force dut.flush_cnt = 16'hFFFD;
      @(negedge clk);
      release dut.stall_cnt;
      release dut.flush_cnt;
      tick();
      tick();
      tick();
      check("sat_stall", {16'b0, stall_cnt}, 32'h0000_FFFF);
      flush = 1'b1;
      tick();
      tick();
      tick();
      check("sat_flush", {16'b0, flush_cnt}, 32'h0000_FFFF);
      check("sat_stall_hold", {16'b0, stall_cnt}, 32'h0000_FFFF);
      flush = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
